// File: rtl/div_pkg.sv
// Shared types for the sequential signed divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    DIVIDE  = 3'd2,
    CORRECT = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/div_step.sv
// One non-restoring iteration: shift {pr,q} left, add or subtract |divisor|,
// and shift in the new quotient bit taken from the sign of the result.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   pr_i,
  input  logic [N-1:0] q_i,
  input  logic [N:0]   dmag_i,
  output logic [N:0]   pr_o,
  output logic [N-1:0] q_o
);

  logic [N:0] shifted;

  assign shifted = {pr_i[N-1:0], q_i[N-1]};
  assign pr_o    = pr_i[N] ? (shifted + dmag_i) : (shifted - dmag_i);
  assign q_o     = {q_i[N-2:0], ~pr_o[N]};

endmodule

// File: rtl/nonrestoring_divider.sv
// Multi-cycle signed divider (truncating), non-restoring core on magnitudes
// with a final sign/remainder correction pass.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_t         state_q, state_d;
  logic [N-1:0]   dvd_q, dvs_q;
  logic [N:0]     pr_q, dmag_q;
  logic [N-1:0]   acc_q;
  logic           qsign_q, rsign_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   quo_q, rem_q;
  logic           dbz_q, ovf_q;

  logic [N:0]     dvs_ext, dvs_mag;
  logic [N-1:0]   dvd_mag;
  logic [N:0]     step_pr;
  logic [N-1:0]   step_q;
  logic [N-1:0]   rem_mag;

  // The quotient magnitude of -2^(N-1) is 2^(N-1), which still fits N unsigned bits.
  assign dvd_mag = dvd_q[N-1] ? -dvd_q : dvd_q;
  assign dvs_ext = {dvs_q[N-1], dvs_q};
  assign dvs_mag = dvs_q[N-1] ? -dvs_ext : dvs_ext;
  assign rem_mag = pr_q[N] ? (pr_q[N-1:0] + dmag_q[N-1:0]) : pr_q[N-1:0];

  div_step #(.N(N)) u_step (
    .pr_i   (pr_q),
    .q_i    (acc_q),
    .dmag_i (dmag_q),
    .pr_o   (step_pr),
    .q_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = (dvs_q == '0) ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == CW'(N - 1)) state_d = CORRECT;
      CORRECT: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      dmag_q  <= '0;
      acc_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
          end
        end
        SETUP: begin
          dmag_q  <= dvs_mag;
          acc_q   <= dvd_mag;
          pr_q    <= '0;
          qsign_q <= dvd_q[N-1] ^ dvs_q[N-1];
          rsign_q <= dvd_q[N-1];
          cnt_q   <= '0;
          ovf_q   <= (dvd_q == MIN_VAL) && (dvs_q == '1);
          if (dvs_q == '0) begin
            dbz_q <= 1'b1;
            quo_q <= '1;
            rem_q <= dvd_q;
          end
        end
        DIVIDE: begin
          pr_q  <= step_pr;
          acc_q <= step_q;
          cnt_q <= cnt_q + CW'(1);
        end
        CORRECT: begin
          quo_q <= qsign_q ? -acc_q : acc_q;
          rem_q <= rsign_q ? -rem_mag : rem_mag;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 The block SHALL take parameter N, default 4: operand width in bits; legal values are N >= 2.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port reset: input, 1 bit, asynchronous, active-high.
REQ-005 Port start: input, 1 bit, request to begin a division; sampled only in IDLE.
REQ-006 Port dividend: input, N bits, two's complement; sampled with start.
REQ-007 Port divisor: input, N bits, two's complement; sampled with start.
REQ-008 Port busy: output, 1 bit; high in every state except IDLE.
REQ-009 Port done: output, 1 bit; one-cycle pulse, results valid.
REQ-010 Port quotient: output, N bits, two's complement.
REQ-011 Port remainder: output, N bits, two's complement.
REQ-012 Port div_by_zero: output, 1 bit, error flag; valid with done and held with the results.
REQ-013 Port overflow: output, 1 bit, error flag; valid with done and held with the results.

Function
REQ-014 The block SHALL implement the FSM IDLE -> SETUP -> DIVIDE -> CORRECT -> DONE -> IDLE.
REQ-015 In IDLE with start=1, the block SHALL register dividend and divisor, go to SETUP, and clear div_by_zero and overflow.
REQ-016 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-017 In SETUP, the block SHALL store the operand magnitudes, quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign), clear the iteration counter, and go to DIVIDE.
REQ-018 In SETUP with a zero divisor, the block SHALL skip DIVIDE and CORRECT and go directly to DONE.
REQ-019 DIVIDE SHALL last exactly N cycles, performing one non-restoring step per cycle on an (N+1)-bit signed partial remainder.
REQ-020 Each DIVIDE step SHALL: shift the partial remainder and quotient left by one; subtract |divisor| if the partial remainder is >= 0, otherwise add it; set the new quotient bit to 1 if the result is >= 0.
REQ-021 In CORRECT, the block SHALL add |divisor| once if the partial remainder is negative, negate the quotient if the quotient sign is 1, negate the remainder if the remainder sign is 1, then go to DONE.
REQ-022 Quotient SHALL truncate toward zero; a nonzero remainder SHALL take the sign of the dividend.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-024 Latency SHALL be N+3 cycles from the clock edge that samples start to the first cycle done is high.
REQ-025 quotient, remainder, div_by_zero and overflow SHALL hold until the next accepted start or reset.
REQ-026 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 start asserted during the DONE cycle SHALL be ignored; the earliest accepted start is in the IDLE cycle that follows.
REQ-028 On divisor=0, the block SHALL output div_by_zero=1, quotient all ones, remainder = dividend and overflow=0, with done high 2 cycles after start is sampled.
REQ-029 On dividend = -2^(N-1) and divisor = -1, the block SHALL output overflow=1, quotient = -2^(N-1) (wrapped) and remainder 0.
REQ-030 Operand magnitudes SHALL be held in N+1 bits so that |-2^(N-1)| is represented without loss.
REQ-031 Inputs SHALL be ignored outside the IDLE sampling cycle; changing them mid-operation SHALL NOT affect the result.

Reset
REQ-032 While reset=1, asynchronously, the state SHALL be IDLE and busy, done, quotient, remainder, div_by_zero, overflow and the counter SHALL all be 0.
REQ-033 Reset asserted mid-operation SHALL abort the division with no done pulse, and the first start after reset deasserts SHALL be accepted normally.

Structure
REQ-034 Package div_pkg SHALL hold the state enum typedef (IDLE, SETUP, DIVIDE, CORRECT, DONE).
REQ-035 The DIVIDE iteration SHALL be the combinational sub-module div_step, parameterized by N: (partial remainder, quotient, |divisor|) in, next values out.
REQ-036 The counter SHALL be $clog2(N)+1 bits wide.

Verification (N=4)
REQ-037 The bench SHALL check: 7 / 2 -> quotient 3, remainder 1, done exactly 7 cycles after start, done high exactly 1 cycle.
REQ-038 The bench SHALL check: -7 / 2 -> quotient 4'b1101 (-3), remainder 4'b1111 (-1); 7 / -2 -> quotient -3, remainder 1; -8 / 3 -> quotient -2, remainder -2.
REQ-039 The bench SHALL check: -8 / -1 -> overflow=1, quotient 4'b1000, remainder 0, div_by_zero=0.
REQ-040 The bench SHALL check: 5 / 0 -> div_by_zero=1, quotient 4'b1111, remainder 5, done 2 cycles after start.
REQ-041 The bench SHALL check: start pulsed again at cycle 3 of a 6 / 3 operation -> ignored; single done with quotient 2, remainder 0.
REQ-042 The bench SHALL check: reset asserted at cycle 4 of a 7 / 2 operation -> all outputs 0 immediately, no done; a subsequent 7 / 2 -> quotient 3, remainder 1.
